// File: rtl/free_list.sv
// Physical-register free list for a 3-wide rename stage.
// Circular array of CAP free PR tags: allocation pops from head, retirement
// pushes freed tags at tail, count tracks occupancy (0..CAP). Allocation is
// combinational from registered state, so pushes become visible next cycle.
module free_list #(
  parameter int unsigned NUM_PR    = 64,
  parameter int unsigned ARCH_REGS = 32,
  localparam int unsigned PR       = $clog2(NUM_PR)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  input  logic [2:0]           DispatchEN,
  input  logic [2:0]           Retire_EN,
  input  logic [2:0][PR-1:0]   Tolds_in,
  output logic [2:0][PR-1:0]   free_pr,
  output logic [2:0]           grant,
  output logic [1:0]           avail_num,
  output logic                 overflow_err
);

  localparam int unsigned CAP = NUM_PR - ARCH_REGS;
  localparam int unsigned PW  = $clog2(CAP);
  localparam int unsigned CW  = PW + 1;

  logic [CAP-1:0][PR-1:0] r_mem;
  logic [PW-1:0]          r_head;
  logic [PW-1:0]          r_tail;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;

  logic [2:0][1:0]        w_arank;
  logic [2:0][1:0]        w_prank;
  logic [1:0]             w_ngrant;
  logic [1:0]             w_npush;
  logic [CW:0]            w_cnt_sum;
  logic                   w_over;
  logic [PW-1:0]          w_head_n;
  logic [PW-1:0]          w_tail_n;
  logic [CW-1:0]          w_count_n;

  // Rank of each slot among requesting / pushing slots, oldest (slot 2) first.
  always_comb begin
    w_arank[2] = 2'd0;
    w_arank[1] = {1'b0, DispatchEN[2]};
    w_arank[0] = {1'b0, DispatchEN[2]} + {1'b0, DispatchEN[1]};
    w_prank[2] = 2'd0;
    w_prank[1] = {1'b0, Retire_EN[2]};
    w_prank[0] = {1'b0, Retire_EN[2]} + {1'b0, Retire_EN[1]};
  end

  // Grant a request only if enough entries exist for its rank; squash blocks all.
  always_comb begin
    grant   = 3'b000;
    free_pr = '0;
    for (int s = 0; s < 3; s++) begin
      grant[s]   = !squash && DispatchEN[s] && (CW'(w_arank[s]) < r_count);
      free_pr[s] = r_mem[r_head + PW'(w_arank[s])];
    end
  end

  // Next-state pointers and occupancy; squash resets the list to full.
  always_comb begin
    w_ngrant  = {1'b0, grant[2]} + {1'b0, grant[1]} + {1'b0, grant[0]};
    w_npush   = {1'b0, Retire_EN[2]} + {1'b0, Retire_EN[1]} + {1'b0, Retire_EN[0]};
    // Grants never exceed count, so this difference cannot underflow.
    w_cnt_sum = {1'b0, r_count} + (CW+1)'(w_npush) - (CW+1)'(w_ngrant);
    w_over    = !squash && (w_cnt_sum > (CW+1)'(CAP));
    w_tail_n  = r_tail + PW'(w_npush);
    if (squash) begin
      w_head_n  = w_tail_n;
      w_count_n = CW'(CAP);
    end else begin
      w_head_n  = r_head + PW'(w_ngrant);
      w_count_n = w_over ? CW'(CAP) : w_cnt_sum[CW-1:0];
    end
  end

  // Registered state: array contents, pointers, count, sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CAP; i++) begin
        r_mem[i] <= PR'(ARCH_REGS + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CW'(CAP);
      r_ovf   <= 1'b0;
    end else begin
      for (int s = 0; s < 3; s++) begin
        if (Retire_EN[s]) begin
          r_mem[r_tail + PW'(w_prank[s])] <= Tolds_in[s];
        end
      end
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
      r_ovf   <= r_ovf | w_over;
    end
  end

  // Outputs derived from registered state.
  always_comb begin
    avail_num    = (r_count >= CW'(3)) ? 2'd3 : r_count[1:0];
    overflow_err = r_ovf;
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset values, in-order allocation, sparse
// requests, draining, same-cycle push invisibility, squash recovery, overflow.
module tb_free_list;

  localparam int unsigned PR = 6;

  logic                clock;
  logic                reset;
  logic                squash;
  logic [2:0]          DispatchEN;
  logic [2:0]          Retire_EN;
  logic [2:0][PR-1:0]  Tolds_in;
  logic [2:0][PR-1:0]  free_pr;
  logic [2:0]          grant;
  logic [1:0]          avail_num;
  logic                overflow_err;

  int total;
  int bad;

  free_list #(
    .NUM_PR    (64),
    .ARCH_REGS (32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .DispatchEN   (DispatchEN),
    .Retire_EN    (Retire_EN),
    .Tolds_in     (Tolds_in),
    .free_pr      (free_pr),
    .grant        (grant),
    .avail_num    (avail_num),
    .overflow_err (overflow_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    squash     = 1'b0;
    DispatchEN = 3'b000;
    Retire_EN  = 3'b000;
    Tolds_in   = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(dut.r_count), 32);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_avail", 32'(avail_num), 3);
    chk("rst_ovf", 32'(overflow_err), 0);
    DispatchEN = 3'b100;
    #1;
    chk("rst_fp2", 32'(free_pr[2]), 32);
    idle();
    reset = 1'b1;
    #1;
    chk("post_rst_avail", 32'(avail_num), 3);

    // Full three-wide allocation from a full list.
    DispatchEN = 3'b111;
    #1;
    chk("a111_grant", 32'(grant), 32'b111);
    chk("a111_fp2", 32'(free_pr[2]), 32);
    chk("a111_fp1", 32'(free_pr[1]), 33);
    chk("a111_fp0", 32'(free_pr[0]), 34);
    tick();
    idle();
    chk("a111_count", 32'(dut.r_count), 29);
    chk("a111_head", 32'(dut.r_head), 3);

    // Mid-operation reset restores the full list; then a sparse request.
    do_reset();
    DispatchEN = 3'b101;
    #1;
    chk("a101_grant", 32'(grant), 32'b101);
    chk("a101_fp2", 32'(free_pr[2]), 32);
    chk("a101_fp0", 32'(free_pr[0]), 33);
    tick();
    idle();
    chk("a101_count", 32'(dut.r_count), 30);

    // Drain to two entries (head=30), then over-request.
    for (int i = 0; i < 9; i++) begin
      DispatchEN = 3'b111;
      tick();
    end
    DispatchEN = 3'b001;
    tick();
    idle();
    chk("drain_avail_before", 32'(avail_num), 2);
    DispatchEN = 3'b111;
    #1;
    chk("drain_grant", 32'(grant), 32'b110);
    chk("drain_fp2", 32'(free_pr[2]), 62);
    chk("drain_fp1", 32'(free_pr[1]), 63);
    tick();
    chk("empty_avail", 32'(avail_num), 0);
    chk("empty_grant", 32'(grant), 0);

    // Refill one entry (tag 20), then request with same-cycle pushes.
    idle();
    Retire_EN   = 3'b100;
    Tolds_in[2] = 6'd20;
    tick();
    idle();
    chk("one_avail", 32'(avail_num), 1);
    DispatchEN  = 3'b111;
    Retire_EN   = 3'b011;
    Tolds_in[1] = 6'd5;
    Tolds_in[0] = 6'd9;
    #1;
    chk("push_hidden_grant", 32'(grant), 32'b100);
    chk("push_hidden_fp2", 32'(free_pr[2]), 20);
    tick();
    idle();
    chk("push_tail", 32'(dut.r_tail), 3);
    chk("push_count", 32'(dut.r_count), 2);
    DispatchEN = 3'b110;
    #1;
    chk("freed_grant", 32'(grant), 32'b110);
    chk("freed_fp2", 32'(free_pr[2]), 5);
    chk("freed_fp1", 32'(free_pr[1]), 9);
    tick();
    idle();

    // Squash recovery: allocate 10, retire 4, squash while pushing tag 7.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      DispatchEN = 3'b111;
      tick();
    end
    DispatchEN = 3'b100;
    tick();
    idle();
    Retire_EN = 3'b111;
    Tolds_in  = {6'd1, 6'd2, 6'd3};
    tick();
    idle();
    Retire_EN   = 3'b100;
    Tolds_in[2] = 6'd4;
    tick();
    idle();
    chk("pre_sq_count", 32'(dut.r_count), 26);
    squash      = 1'b1;
    DispatchEN  = 3'b111;
    Retire_EN   = 3'b001;
    Tolds_in[0] = 6'd7;
    #1;
    chk("sq_grant", 32'(grant), 0);
    tick();
    idle();
    chk("sq_count", 32'(dut.r_count), 32);
    chk("sq_head", 32'(dut.r_head), 5);
    chk("sq_tail", 32'(dut.r_tail), 5);
    DispatchEN = 3'b111;
    #1;
    // Head lands on entry 5 (tail after five pushes): original tags 37..39.
    chk("sq_fp2", 32'(free_pr[2]), 37);
    chk("sq_fp1", 32'(free_pr[1]), 38);
    chk("sq_fp0", 32'(free_pr[0]), 39);
    tick();
    idle();

    // Overflow: push into a full list.
    do_reset();
    Retire_EN   = 3'b100;
    Tolds_in[2] = 6'd1;
    tick();
    idle();
    chk("ovf_set", 32'(overflow_err), 1);
    chk("ovf_count", 32'(dut.r_count), 32);
    DispatchEN = 3'b111;
    tick();
    idle();
    chk("ovf_sticky", 32'(overflow_err), 1);
    reset = 1'b0;
    #1;
    chk("ovf_cleared", 32'(overflow_err), 0);
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
